// File: rtl/router_fifo_buf_if.sv
// Bundle of the write (synchronizer) and read (client) side signals of one router output FIFO.
// master = synchronizer/client side driving strobes, slave = the FIFO itself.
interface router_fifo_buf_if #(
    parameter int WIDTH = 8
);
    // Handshake: a write is taken on a rising clock edge when write_enb=1 and full=0;
    // a read is taken when read_enb=1 and empty=0, and its byte appears on data_out one cycle later.
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             pkt_busy;
    logic             full;
    logic             empty;
    logic [6:0]       dbg_count;

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, pkt_busy, full, empty, dbg_count
    );

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, pkt_busy, full, empty, dbg_count
    );
endinterface

// File: rtl/router_fifo_buf.sv
// Per-port output FIFO of the 1x3 router with read-side packet byte counter.
// Optional macro ROUTER_FIFO_TRISTATE_EN: data_out floats when no packet is being drained.
module router_fifo_buf #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    router_fifo_buf_if.slave  bus
);

    logic [WIDTH:0]   mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [6:0]       count;
    logic [6:0]       count_d;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH:0]   rd_word;
    logic             full_w;
    logic             empty_w;
    logic             clr;
    logic             wr_acc;
    logic             rd_acc;

    // Wrap bit in the MSB distinguishes full from empty when the low bits match.
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign clr     = reset | soft_reset;
    assign wr_acc  = bus.write_enb & ~full_w & ~clr;
    assign rd_acc  = bus.read_enb & ~empty_w & ~clr;
    assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

    // Header byte loads payload length + parity; later bytes count down to zero.
    always_comb begin
        count_d = count;
        if (rd_acc) begin
            if (rd_word[WIDTH]) begin
                count_d = {1'b0, rd_word[7:2]} + 7'd1;
            end else if (count != 7'd0) begin
                count_d = count - 7'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= rd_word[WIDTH-1:0];
            end
            count <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

`ifdef ROUTER_FIFO_TRISTATE_EN
    logic oe_q;

    always_ff @(posedge clock) begin
        if (clr) begin
            oe_q <= 1'b0;
        end else begin
            oe_q <= rd_acc || (count_d != 7'd0);
        end
    end

    assign bus.data_out = oe_q ? dout_q : {WIDTH{1'bz}};
`else
    assign bus.data_out = dout_q;
`endif

    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.pkt_busy  = (count != 7'd0);
    assign bus.dbg_count = count;

endmodule

// File: tb/tb_router_fifo_buf.sv
// Randomized scoreboard bench for router_fifo_buf against a queue-based reference model.
module tb_router_fifo_buf;

    logic clock = 1'b0;
    logic reset;
    logic soft_reset;

    router_fifo_buf_if #(.WIDTH(8)) bus ();

    router_fifo_buf #(.DEPTH(16), .WIDTH(8), .ADDR_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  dout;
        logic [6:0]  count;
        logic        empty;
        logic        full;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    logic [8:0]  m_q[$];
    int          m_count;
    logic [7:0]  m_dout;
    bit          m_oe;
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Drive one cycle and push the model's view of the state after the coming edge.
    task automatic step(input bit rst, input bit srst, input bit we, input bit lfd,
                        input logic [7:0] din, input bit re);
        exp_t       e;
        bit         rd;
        bit         wr;
        logic [8:0] w;
        @(posedge clock);
        #1;
        reset         = rst;
        soft_reset    = srst;
        bus.write_enb = we;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        bus.read_enb  = re;
        if (rst || srst) begin
            m_q.delete();
            m_count = 0;
            m_dout  = 8'h00;
            m_oe    = 1'b0;
        end else begin
            rd = re && (m_q.size() != 0);
            wr = we && (m_q.size() != 16);
            if (rd) begin
                w = m_q.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_count = int'(w[7:2]) + 1;
                else if (m_count != 0) m_count = m_count - 1;
            end
            if (wr) m_q.push_back({lfd, din});
            m_oe = rd || (m_count != 0);
        end
        e.cyc   = cyc + 1;
`ifdef ROUTER_FIFO_TRISTATE_EN
        e.dout  = m_oe ? m_dout : 8'hzz;
`else
        e.dout  = m_dout;
`endif
        e.count = 7'(m_count);
        e.empty = (m_q.size() == 0);
        e.full  = (m_q.size() == 16);
        e.busy  = (m_count != 0);
        exp_q.push_back(e);
    endtask

    task automatic wr_b(input logic [7:0] d, input bit lfd);
        step(0, 0, 1, lfd, d, 0);
    endtask

    task automatic rd_b();
        step(0, 0, 0, 0, 8'h00, 1);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 8'h00, 0);
    endtask

    // Monitor: compares every expectation whose edge has already happened.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            cyc++;
            #3;
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                cmp("data_out", {24'h0, bus.data_out}, {24'h0, e.dout});
                cmp("count",    {25'h0, bus.dbg_count}, {25'h0, e.count});
                cmp("empty",    {31'h0, bus.empty}, {31'h0, e.empty});
                cmp("full",     {31'h0, bus.full}, {31'h0, e.full});
                cmp("pkt_busy", {31'h0, bus.pkt_busy}, {31'h0, e.busy});
            end
        end
    end

    initial begin
        int occ;
        int sel;
        reset         = 1'b1;
        soft_reset    = 1'b0;
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = 8'h00;
        bus.read_enb  = 1'b0;

        // Reset held for two cycles.
        step(1, 0, 0, 0, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 0);

        // One packet: header 0E gives count 4, then drains to 0.
        wr_b(8'h0E, 1);
        wr_b(8'hA1, 0);
        wr_b(8'hA2, 0);
        wr_b(8'hA3, 0);
        wr_b(8'h5C, 0);
        repeat (5) rd_b();
        idle();

        // Fill to full, drop a 17th write, drain.
        for (int i = 0; i < 16; i++) wr_b(8'(i), 0);
        wr_b(8'hFF, 0);
        repeat (16) rd_b();
        idle();

        // Simultaneous read and write while full.
        for (int i = 0; i < 16; i++) wr_b(8'(8'h30 + i), 0);
        step(0, 0, 1, 0, 8'h77, 1);
        idle();
        repeat (16) rd_b();
        idle();

        // Soft reset together with a read, five entries left and count 3.
        wr_b(8'h0A, 1);
        for (int i = 1; i <= 5; i++) wr_b(8'(i), 0);
        rd_b();
        step(0, 1, 0, 0, 8'h00, 1);
        idle();

        // Low-occupancy interleaving to wrap the pointers repeatedly.
        wr_b(8'($urandom_range(0, 255)), 0);
        for (int i = 0; i < 80; i++) begin
            occ = m_q.size();
            sel = $urandom_range(0, 2);
            if (occ <= 1 && sel == 2) sel = 0;
            if (occ >= 3 && sel == 0) sel = 2;
            case (sel)
                0: wr_b(8'($urandom_range(0, 255)), 0);
                1: step(0, 0, 1, 0, 8'($urandom_range(0, 255)), 1);
                default: rd_b();
            endcase
        end
        repeat (4) rd_b();

        // Fully random traffic including headers and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 2) != 0));
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
        #5;
        cmp("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
